imm_gen_stage: RTL and testbench
================================

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, datapath and immediate width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  IF/ID slot holds a real instruction.
REQ-006 SHALL have port in_instr  input  INSTR_W  instruction word from IF/ID.
REQ-007 SHALL have port in_pc  input  DATA_W  PC of in_instr.
REQ-008 SHALL have port stall  input  1  hazard-unit hold request.
REQ-009 SHALL have port flush  input  1  branch-taken squash request.
REQ-010 SHALL have port out_valid  output  1  ID/EX slot valid.
REQ-011 SHALL have port out_imm  output  DATA_W  extended immediate, registered.
REQ-012 SHALL have port out_imm_type  output  3  immediate class: NONE, D, I, CB, B, IW.
REQ-013 SHALL have port out_pc  output  DATA_W  registered copy of in_pc.

Function
REQ-014 SHALL decode in_instr[31:21] combinationally, using the first matching rule in this order: B/BL (6-bit opcode 000101/100101) -> B, imm[25:0] sign-extended; CBZ/CBNZ/B.cond (8-bit opcode 10110100/10110101/01010100) -> CB, imm[23:5] sign-extended; MOVZ (9-bit opcode 110100101) -> IW; ADDI/SUBI (10-bit opcode 1001000100/1101000100) -> I, imm[21:10] zero-extended; LDUR/STUR (11-bit opcode 11111000010/11111000000) -> D, imm[20:12] sign-extended; any other opcode -> NONE, imm 0.
REQ-015 SHALL form the IW immediate by zero-extending imm16 = instr[20:5] and shifting it left by 16*instr[22:21].
REQ-016 SHALL NOT shift branch offsets; the result is a word offset, and the EX branch adder applies the <<2.
REQ-017 SHALL have a latency of 1 cycle: values decoded in cycle N appear on the outputs in cycle N+1.
REQ-018 SHALL, when stall=1 and flush=0, hold all outputs unchanged.
REQ-019 SHALL, when flush=1, load out_valid=0, out_imm=0 and out_imm_type=NONE on the next edge, regardless of stall (flush has priority).
REQ-020 SHALL, when in_valid=0 and no stall/flush is active, load a bubble (out_valid=0, out_imm=0, out_imm_type=NONE) and still register out_pc.
REQ-021 SHALL, for an undefined opcode with in_valid=1, set out_valid=1 and out_imm_type=NONE; no exception logic is required.

Reset
REQ-022 SHALL, while reset=0, force out_valid=0, out_imm=0, out_imm_type=NONE and out_pc=0 immediately, independent of clk.
REQ-023 SHALL, on deassertion of reset, accept input at the first rising clk edge; an instruction present when reset is asserted mid-operation is discarded and is not replayed.

Structure
REQ-024 SHALL use shared package cpu_pkg for the imm_type_e enum (NONE=0, D=1, I=2, CB=3, B=4, IW=5) and the opcode constants.
REQ-025 SHALL place the combinational decode and extension of REQ-014 and REQ-015 in one sub-module, imm_decode; imm_gen_stage holds only the ID/EX registers and the stall/flush control.

Verification
REQ-026 SHALL cover: in_instr=0xF85F8041 (LDUR X1,[X2,#-8]), in_valid=1 -> next cycle out_imm=0xFFFFFFFFFFFFFFF8, out_imm_type=D, out_valid=1.
REQ-027 SHALL cover: 0x913FFC00 (ADDI #4095) -> out_imm=0x0000000000000FFF, type=I; then 0x17FFFFFF (B -1) -> out_imm=0xFFFFFFFFFFFFFFFF, type=B.
REQ-028 SHALL cover: 0xB4000083 (CBZ X3,+4) -> out_imm=0x4, type=CB; 0xD2A24685 (MOVZ X5,#0x1234,LSL 16) -> out_imm=0x0000000012340000, type=IW.
REQ-029 SHALL cover: stall=1 for 3 cycles while in_instr changes -> outputs frozen at the prior value; then stall=1 and flush=1 together -> out_valid=0 and out_imm=0 next cycle.
REQ-030 SHALL cover: reset driven low between clock edges while out_valid=1 -> all outputs 0 within the same cycle; after release, the first edge with in_valid=1 loads normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: immediate classes and LEGv8 opcode patterns for the
// decode stage.
package cpu_pkg;

  typedef enum logic [2:0] {
    ImmNone = 3'd0,
    ImmD    = 3'd1,
    ImmI    = 3'd2,
    ImmCb   = 3'd3,
    ImmB    = 3'd4,
    ImmIw   = 3'd5
  } imm_type_e;

  // Opcodes are matched on the leading bits of instr[31:21]; width varies per format
  localparam logic [5:0]  OpB      = 6'b000101;
  localparam logic [5:0]  OpBl     = 6'b100101;
  localparam logic [7:0]  OpCbz    = 8'b10110100;
  localparam logic [7:0]  OpCbnz   = 8'b10110101;
  localparam logic [7:0]  OpBcond  = 8'b01010100;
  localparam logic [8:0]  OpMovz   = 9'b110100101;
  localparam logic [9:0]  OpAddi   = 10'b1001000100;
  localparam logic [9:0]  OpSubi   = 10'b1101000100;
  localparam logic [10:0] OpLdur   = 11'b11111000010;
  localparam logic [10:0] OpStur   = 11'b11111000000;

  localparam int unsigned ImmBW    = 26;
  localparam int unsigned ImmCbW   = 19;
  localparam int unsigned ImmIW    = 12;
  localparam int unsigned ImmDW    = 9;
  localparam int unsigned ImmIwW   = 16;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode classification and immediate extension for one
// instruction word. Branch offsets stay in words; EX applies the <<2.
module imm_decode
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  imm,
  output imm_type_e          imm_type
);

  logic [5:0]  op6;
  logic [7:0]  op8;
  logic [8:0]  op9;
  logic [9:0]  op10;
  logic [10:0] op11;

  logic [DATA_W-1:0] imm_b;
  logic [DATA_W-1:0] imm_cb;
  logic [DATA_W-1:0] imm_i;
  logic [DATA_W-1:0] imm_d;
  logic [DATA_W-1:0] imm_iw;
  logic [DATA_W-1:0] imm16_ext;
  logic [1:0]        hw;

  // Register fields are irrelevant to immediate generation
  logic unused_rd;
  assign unused_rd = ^instr[4:0];

  assign op6  = instr[31:26];
  assign op8  = instr[31:24];
  assign op9  = instr[31:23];
  assign op10 = instr[31:22];
  assign op11 = instr[31:21];

  assign imm_b     = {{(DATA_W - ImmBW){instr[25]}}, instr[25:0]};
  assign imm_cb    = {{(DATA_W - ImmCbW){instr[23]}}, instr[23:5]};
  assign imm_i     = {{(DATA_W - ImmIW){1'b0}}, instr[21:10]};
  assign imm_d     = {{(DATA_W - ImmDW){instr[20]}}, instr[20:12]};
  assign imm16_ext = {{(DATA_W - ImmIwW){1'b0}}, instr[20:5]};
  assign hw        = instr[22:21];

  always_comb begin
    imm_iw = imm16_ext;
    unique case (hw)
      2'd0: imm_iw = imm16_ext;
      2'd1: imm_iw = imm16_ext << 16;
      2'd2: imm_iw = imm16_ext << 32;
      2'd3: imm_iw = imm16_ext << 48;
      default: imm_iw = imm16_ext;
    endcase
  end

  // First match wins, from the shortest opcode to the longest
  always_comb begin
    imm      = '0;
    imm_type = ImmNone;
    if (op6 == OpB || op6 == OpBl) begin
      imm      = imm_b;
      imm_type = ImmB;
    end else if (op8 == OpCbz || op8 == OpCbnz || op8 == OpBcond) begin
      imm      = imm_cb;
      imm_type = ImmCb;
    end else if (op9 == OpMovz) begin
      imm      = imm_iw;
      imm_type = ImmIw;
    end else if (op10 == OpAddi || op10 == OpSubi) begin
      imm      = imm_i;
      imm_type = ImmI;
    end else if (op11 == OpLdur || op11 == OpStur) begin
      imm      = imm_d;
      imm_type = ImmD;
    end
  end

endmodule

// File: rtl/imm_gen_stage.sv
// ID/EX pipeline register for the immediate path, with hazard stall and
// branch flush control around the imm_decode block.
module imm_gen_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_pc,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_imm,
  output imm_type_e          out_imm_type,
  output logic [DATA_W-1:0]  out_pc
);

  logic [DATA_W-1:0] dec_imm;
  imm_type_e         dec_type;

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] imm_d, imm_q;
  imm_type_e         type_d, type_q;
  logic [DATA_W-1:0] pc_d, pc_q;

  imm_decode #(
    .DATA_W  (DATA_W),
    .INSTR_W (INSTR_W)
  ) u_imm_decode (
    .instr    (in_instr),
    .imm      (dec_imm),
    .imm_type (dec_type)
  );

  // Flush beats stall; an invalid slot becomes a bubble but still carries its PC
  always_comb begin
    valid_d = valid_q;
    imm_d   = imm_q;
    type_d  = type_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
      imm_d   = '0;
      type_d  = ImmNone;
      pc_d    = in_pc;
    end else if (!stall) begin
      valid_d = in_valid;
      imm_d   = in_valid ? dec_imm : '0;
      type_d  = in_valid ? dec_type : ImmNone;
      pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      imm_q   <= '0;
      type_q  <= ImmNone;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      imm_q   <= imm_d;
      type_q  <= type_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_imm      = imm_q;
  assign out_imm_type = type_q;
  assign out_pc       = pc_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: decode formats, bubbles, stall/flush and
// asynchronous reset behaviour.
module tb_imm_gen_stage;
  import cpu_pkg::*;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned INSTR_W = 32;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic [DATA_W-1:0]  in_pc;
  logic               stall;
  logic               flush;
  logic               out_valid;
  logic [DATA_W-1:0]  out_imm;
  imm_type_e          out_imm_type;
  logic [DATA_W-1:0]  out_pc;

  int n_tests;
  int n_fail;

  imm_gen_stage #(
    .DATA_W  (DATA_W),
    .INSTR_W (INSTR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .stall        (stall),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_imm      (out_imm),
    .out_imm_type (out_imm_type),
    .out_pc       (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'hF85F8041;
    in_pc    = 64'h100;
    stall    = 1'b0;
    flush    = 1'b0;
    #2;
    n_tests++;
    if (out_valid !== 1'b0 || out_imm !== 64'd0 || out_imm_type !== ImmNone
        || out_pc !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b imm=%h t=%0d pc=%h want 0/0/0/0",
               out_valid, out_imm, out_imm_type, out_pc);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_imm !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_hold_edge: got v=%b imm=%h want 0/0", out_valid, out_imm);
    end
    reset = 1'b1;
  endtask

  // Table of instruction -> expected immediate and class, one cycle later
  task automatic test_decode();
    logic [31:0] instrs [10];
    logic [63:0] imms   [10];
    imm_type_e   types  [10];
    instrs[0] = 32'hF85F8041; imms[0] = 64'hFFFFFFFFFFFFFFF8; types[0] = ImmD;
    instrs[1] = 32'h913FFC00; imms[1] = 64'h0000000000000FFF; types[1] = ImmI;
    instrs[2] = 32'h17FFFFFF; imms[2] = 64'hFFFFFFFFFFFFFFFF; types[2] = ImmB;
    instrs[3] = 32'hB4000083; imms[3] = 64'h0000000000000004; types[3] = ImmCb;
    instrs[4] = 32'hD2A24685; imms[4] = 64'h0000000012340000; types[4] = ImmIw;
    instrs[5] = 32'hD1000400; imms[5] = 64'h0000000000000001; types[5] = ImmI;
    instrs[6] = 32'h54FFFFE0; imms[6] = 64'hFFFFFFFFFFFFFFFF; types[6] = ImmCb;
    instrs[7] = 32'h94000010; imms[7] = 64'h0000000000000010; types[7] = ImmB;
    instrs[8] = 32'hF8010000; imms[8] = 64'h0000000000000010; types[8] = ImmD;
    instrs[9] = 32'hD2E00020; imms[9] = 64'h0001000000000000; types[9] = ImmIw;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_instr = instrs[i];
      in_pc    = 64'h4000 + 64'(i * 4);
      n_tests++;
      if (i > 0 && out_imm !== imms[i-1]) begin
        n_fail++;
        $display("FAIL latency_%0d: imm changed before edge got=%h want=%h",
                 i, out_imm, imms[i-1]);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_imm !== imms[i] || out_imm_type !== types[i]
          || out_pc !== 64'h4000 + 64'(i * 4)) begin
        n_fail++;
        $display("FAIL decode_%0d: instr=%h got v=%b imm=%h t=%0d pc=%h want 1/%h/%0d/%h",
                 i, instrs[i], out_valid, out_imm, out_imm_type, out_pc, imms[i], types[i],
                 64'h4000 + 64'(i * 4));
      end
    end
  endtask

  task automatic test_bubble_undefined();
    in_valid = 1'b0;
    in_instr = 32'hF85F8041;
    in_pc    = 64'h1234;
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_imm !== 64'd0 || out_imm_type !== ImmNone
        || out_pc !== 64'h1234) begin
      n_fail++;
      $display("FAIL bubble: got v=%b imm=%h t=%0d pc=%h want 0/0/0/1234",
               out_valid, out_imm, out_imm_type, out_pc);
    end
    in_valid = 1'b1;
    in_instr = 32'h00000000;
    in_pc    = 64'h2000;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_imm !== 64'd0 || out_imm_type !== ImmNone
        || out_pc !== 64'h2000) begin
      n_fail++;
      $display("FAIL undefined: got v=%b imm=%h t=%0d pc=%h want 1/0/0/2000",
               out_valid, out_imm, out_imm_type, out_pc);
    end
  endtask

  task automatic test_stall_flush();
    in_valid = 1'b1;
    in_instr = 32'h913FFC00;
    in_pc    = 64'h3000;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = (i == 0) ? 32'hF85F8041 : ((i == 1) ? 32'h17FFFFFF : 32'hD2A24685);
      in_pc    = 64'h3100 + 64'(i);
      in_valid = (i != 1);
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_imm !== 64'hFFF || out_imm_type !== ImmI
          || out_pc !== 64'h3000) begin
        n_fail++;
        $display("FAIL stall_%0d: got v=%b imm=%h t=%0d pc=%h want 1/fff/2/3000",
                 i, out_valid, out_imm, out_imm_type, out_pc);
      end
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'hF85F8041;
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_imm !== 64'd0 || out_imm_type !== ImmNone) begin
      n_fail++;
      $display("FAIL stall_flush: got v=%b imm=%h t=%0d want 0/0/0",
               out_valid, out_imm, out_imm_type);
    end
    stall = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_imm !== 64'd0) begin
      n_fail++;
      $display("FAIL flush_only: got v=%b imm=%h want 0/0", out_valid, out_imm);
    end
    flush = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_imm !== 64'hFFFFFFFFFFFFFFF8 || out_imm_type !== ImmD) begin
      n_fail++;
      $display("FAIL after_flush: got v=%b imm=%h t=%0d want 1/fffffffffffffff8/1",
               out_valid, out_imm, out_imm_type);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    in_instr = 32'hB4000083;
    in_pc    = 64'h5000;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_imm !== 64'h4) begin
      n_fail++;
      $display("FAIL pre_reset_load: got v=%b imm=%h want 1/4", out_valid, out_imm);
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_imm !== 64'd0 || out_imm_type !== ImmNone
        || out_pc !== 64'd0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b imm=%h t=%0d pc=%h want 0/0/0/0",
               out_valid, out_imm, out_imm_type, out_pc);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || out_pc !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_discard: got v=%b pc=%h want 0/0", out_valid, out_pc);
    end
    #2;
    reset    = 1'b1;
    in_instr = 32'hD2A24685;
    in_pc    = 64'h6000;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_imm !== 64'h12340000 || out_imm_type !== ImmIw
        || out_pc !== 64'h6000) begin
      n_fail++;
      $display("FAIL post_reset_load: got v=%b imm=%h t=%0d pc=%h want 1/12340000/5/6000",
               out_valid, out_imm, out_imm_type, out_pc);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_decode();
    test_bubble_undefined();
    test_stall_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
